// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single DataMemory port between the CPU memory stage (port C) and
//   the pixel DMA engine (port D). Arbitration is round-robin. D may hold the
//   grant for locked bursts, limited to LOCK_MAX grants while C is waiting.
//   Grants and mem_* are combinational. Read data returns registered, one cycle
//   after issue, to the port that issued the read.
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   c_req/we/vf/addr/wd  CPU request fields; c_gnt issue strobe
//   c_rvalid/c_rdata     CPU registered read return
//   d_*                  DMA request fields, grant and read return; d_lock keeps D owning
//   mem_we/vf/addr/wd    DataMemory request, driven by the granted port (0 when idle)
//   mem_rd               DataMemory combinational read data
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 128,
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic              c_vf,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wd,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_vf,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wd,
  input  logic              d_lock,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_we,
  output logic              mem_vf,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  typedef enum logic {OWN_C, OWN_D} owner_t;

  localparam logic [7:0] LP_LOCK_MAX = 8'(LOCK_MAX);

  owner_t      r_last_owner, w_owner_nxt;
  logic [7:0]  r_lock_cnt, w_lock_nxt;
  logic        w_lock_act;
  logic        w_c_gnt, w_d_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_owner <= OWN_D;
      r_lock_cnt   <= '0;
    end else begin
      r_last_owner <= w_owner_nxt;
      r_lock_cnt   <= w_lock_nxt;
    end
  end

  always_comb begin
    w_c_gnt     = 1'b0;
    w_d_gnt     = 1'b0;
    w_owner_nxt = r_last_owner;
    w_lock_nxt  = r_lock_cnt;
    w_lock_act  = d_lock && (r_last_owner == OWN_D) && (r_lock_cnt < LP_LOCK_MAX);

    if (c_req && d_req) begin
      // Contested: lock keeps D, otherwise the port that did not win last time.
      if (w_lock_act || (r_last_owner == OWN_C)) w_d_gnt = 1'b1;
      else                                       w_c_gnt = 1'b1;
    end else begin
      w_c_gnt = c_req;
      w_d_gnt = d_req;
    end

    if (w_c_gnt) w_owner_nxt = OWN_C;
    if (w_d_gnt) w_owner_nxt = OWN_D;

    // Counts D grants won while C waits; saturation at LOCK_MAX drops the lock
    // so C takes the next contested cycle, whose grant clears the count.
    if (w_c_gnt || !d_lock)
      w_lock_nxt = '0;
    else if (w_d_gnt && c_req && (r_lock_cnt < LP_LOCK_MAX))
      w_lock_nxt = r_lock_cnt + 8'd1;
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_vf   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (w_c_gnt) begin
      mem_we   = c_we;
      mem_vf   = c_vf;
      mem_addr = c_addr;
      mem_wd   = c_wd;
    end else if (w_d_gnt) begin
      mem_we   = d_we;
      mem_vf   = d_vf;
      mem_addr = d_addr;
      mem_wd   = d_wd;
    end
  end

  assign c_gnt = w_c_gnt;
  assign d_gnt = w_d_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      c_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      c_rvalid <= w_c_gnt && !c_we;
      d_rvalid <= w_d_gnt && !d_we;
      if (w_c_gnt && !c_we) c_rdata <= mem_rd;
      if (w_d_gnt && !d_we) d_rdata <= mem_rd;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W   = 128;
  localparam int unsigned DATA_W   = 128;
  localparam int unsigned LOCK_MAX = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic c_req = 0, c_we = 0, c_vf = 0, d_req = 0, d_we = 0, d_vf = 0, d_lock = 0;
  logic [ADDR_W-1:0] c_addr = '0, d_addr = '0;
  logic [DATA_W-1:0] c_wd = '0, d_wd = '0;
  logic c_gnt, d_gnt, c_rvalid, d_rvalid, mem_we, mem_vf;
  logic [DATA_W-1:0] c_rdata, d_rdata, mem_wd, mem_rd;
  logic [ADDR_W-1:0] mem_addr;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_vf(c_vf), .c_addr(c_addr), .c_wd(c_wd),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_vf(d_vf), .d_addr(d_addr), .d_wd(d_wd),
    .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_vf(mem_vf), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Stand-in DataMemory: 16 words selected by the low address bits.
  logic [DATA_W-1:0] bmem [16];
  assign mem_rd = bmem[mem_addr[3:0]];
  always @(posedge clk) if (mem_we) bmem[mem_addr[3:0]] <= mem_wd;

  // Reference model state
  logic [DATA_W-1:0] mmem [16];
  bit   m_last_d = 1'b1;
  int   m_lock   = 0;
  bit   e_crv = 0, e_drv = 0;
  logic [DATA_W-1:0] e_crd = '0, e_drd = '0;
  bit   last_gc, last_gd;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: checks combinational issue at the negedge, advances the model,
  // then checks the registered read return just after the rising edge.
  task automatic cycle();
    bit gc, gd, d_keeps;
    logic [127:0] ea, ewd;
    logic ewe, evf;
    @(negedge clk);
    gc = 0; gd = 0;
    if (c_req && d_req) begin
      d_keeps = d_lock && m_last_d && (m_lock < int'(LOCK_MAX));
      if (d_keeps) gd = 1;
      else begin gc = m_last_d; gd = !m_last_d; end
    end else begin
      gc = c_req; gd = d_req;
    end
    ewe = 0; evf = 0; ea = '0; ewd = '0;
    if (gc) begin ewe = c_we; evf = c_vf; ea = c_addr; ewd = c_wd; end
    if (gd) begin ewe = d_we; evf = d_vf; ea = d_addr; ewd = d_wd; end
    check("c_gnt", c_gnt, gc);
    check("d_gnt", d_gnt, gd);
    check("mem_we", mem_we, ewe);
    check("mem_vf", mem_vf, evf);
    check("mem_addr", mem_addr, ea);
    check("mem_wd", mem_wd, ewd);

    e_crv = gc && !c_we;
    e_drv = gd && !d_we;
    if (e_crv) e_crd = mmem[c_addr[3:0]];
    if (e_drv) e_drd = mmem[d_addr[3:0]];
    if (gc && c_we) mmem[c_addr[3:0]] = c_wd;
    if (gd && d_we) mmem[d_addr[3:0]] = d_wd;
    if (gc) m_last_d = 0;
    if (gd) m_last_d = 1;
    if (gc || !d_lock) m_lock = 0;
    else if (gd && c_req && m_lock < int'(LOCK_MAX)) m_lock++;
    last_gc = gc; last_gd = gd;

    @(posedge clk); #1;
    check("c_rvalid", c_rvalid, e_crv);
    check("d_rvalid", d_rvalid, e_drv);
    check("c_rdata", c_rdata, e_crd);
    check("d_rdata", d_rdata, e_drd);
  endtask

  // Called just after a rising edge; reset is raised and released before the negedge.
  task automatic pulse_reset();
    c_req = 0; d_req = 0;
    rst = 1; #1;
    check("rst_c_rvalid", c_rvalid, 0);
    check("rst_d_rvalid", d_rvalid, 0);
    check("rst_c_rdata", c_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_mem_we", mem_we, 0);
    m_last_d = 1; m_lock = 0; e_crv = 0; e_drv = 0; e_crd = '0; e_drd = '0;
    #1 rst = 0;
  endtask

  task automatic set_c(input logic req, input logic we, input logic vf,
                       input logic [127:0] a, input logic [127:0] wd);
    c_req = req; c_we = we; c_vf = vf; c_addr = a; c_wd = wd;
  endtask

  task automatic set_d(input logic req, input logic we, input logic vf,
                       input logic [127:0] a, input logic [127:0] wd);
    d_req = req; d_we = we; d_vf = vf; d_addr = a; d_wd = wd;
  endtask

  int dcount;
  bit seen_c;

  initial begin
    for (int i = 0; i < 16; i++) begin
      bmem[i] = {4{32'(i * 32'h01010101 + 32'h5a)}};
      mmem[i] = bmem[i];
    end
    repeat (2) @(posedge clk);
    #1;
    pulse_reset();

    // 1: C write then read of a 4-lane vector
    set_c(1, 1, 1, 128'd120000, {32'd4, 32'd3, 32'd2, 32'd1});
    cycle();
    check("t1_wr_gnt", last_gc, 1);
    set_c(1, 0, 1, 128'd120000, '0);
    cycle();
    check("t1_rvalid", c_rvalid, 1);
    check("t1_lanes", c_rdata, {32'd4, 32'd3, 32'd2, 32'd1});
    set_c(0, 0, 0, '0, '0);
    cycle();

    // 2: contested from reset, no lock -> C,D,C,D
    pulse_reset();
    d_lock = 0;
    for (int i = 0; i < 4; i++) begin
      set_c(1, 0, 0, 128'(100 + i), '0);
      set_d(1, 0, 0, 128'(200 + i), '0);
      cycle();
      check("t2_alt_c", last_gc, (i % 2) == 0);
    end

    // 3: locked D bursts: LOCK_MAX D grants, one C grant, then D again
    pulse_reset();
    d_lock = 1;
    set_c(1, 1, 0, 128'd3, rnd128());
    set_d(1, 0, 0, 128'd5, '0);
    dcount = 0; seen_c = 0;
    for (int i = 0; i < 20 && !seen_c; i++) begin
      cycle();
      if (last_gd) dcount++;
      if (last_gc) seen_c = 1;
    end
    check("t3_seen_c", seen_c, 1);
    check("t3_d_burst", dcount, LOCK_MAX);
    cycle();
    check("t3_d_resume", last_gd, 1);
    set_c(0, 0, 0, '0, '0); set_d(0, 0, 0, '0, '0); d_lock = 0;
    cycle();

    // 4: D read at N, C read at N+1, no cross-delivery
    set_d(1, 0, 0, 128'd7, '0);
    cycle();
    check("t4_d_rvalid", d_rvalid, 1);
    check("t4_c_quiet", c_rvalid, 0);
    set_d(0, 0, 0, '0, '0);
    set_c(1, 0, 0, 128'd9, '0);
    cycle();
    check("t4_c_rvalid", c_rvalid, 1);
    check("t4_d_quiet", d_rvalid, 0);
    set_c(0, 0, 0, '0, '0);
    cycle();

    // 5: reset right after a read issue cancels the pending return
    set_c(1, 0, 0, 128'd1, '0);
    cycle();
    pulse_reset();
    check("t5_c_rvalid", c_rvalid, 0);
    cycle();
    set_c(1, 0, 0, 128'd2, '0);
    set_d(1, 0, 0, 128'd4, '0);
    cycle();
    check("t5_c_first", last_gc, 1);
    set_c(0, 0, 0, '0, '0); set_d(0, 0, 0, '0, '0);

    // 6: idle for 5 cycles
    repeat (5) cycle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) d_lock = !d_lock;
      if (!c_req || last_gc || $urandom_range(15) == 0) begin
        if ($urandom_range(2) != 0)
          set_c(1, 1'($urandom), 1'($urandom), rnd128(), rnd128());
        else
          c_req = 0;
      end
      if (!d_req || last_gd || $urandom_range(15) == 0) begin
        if ($urandom_range(3) != 0)
          set_d(1, 1'($urandom), 1'($urandom), rnd128(), rnd128());
        else
          d_req = 0;
      end
      cycle();
      if (i == 300) pulse_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
